// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch / PC-control stage: fetches 16-bit words over req/rdy, issues them
// over valid/ack, and resolves the next PC for B, BR, PCS and HLT from execute's flags.
module fetch_pc_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic [2:0]  flags_in,
    input  logic [15:0] br_reg,
    output logic [15:0] pc_plus2,
    output logic [15:0] pc,
    output logic        hlt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_B  = 4'hC;
    localparam logic [3:0] OP_BR = 4'hD;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] instr_reg, instr_next;
    // Holds imem_req low for the first cycle out of reset.
    logic        started_reg;

    logic        flag_z, flag_v, flag_n;
    logic        taken;
    logic [15:0] seq_pc;
    logic [15:0] branch_off;
    logic [15:0] br_target;
    logic [15:0] resolved_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            instr_reg   <= 16'h0000;
            started_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            started_reg <= 1'b1;
        end
    end

    assign flag_z     = flags_in[2];
    assign flag_v     = flags_in[1];
    assign flag_n     = flags_in[0];
    assign seq_pc     = pc_reg + 16'd2;
    assign branch_off = {{6{instr_reg[8]}}, instr_reg[8:0], 1'b0};
    assign br_target  = br_reg & 16'hFFFE;

    always_comb begin
        taken = 1'b0;
        unique case (instr_reg[11:9])
            3'b000:  taken = !flag_z;
            3'b001:  taken = flag_z;
            3'b010:  taken = !flag_z && !flag_n;
            3'b011:  taken = flag_n;
            3'b100:  taken = flag_z || !flag_n;
            3'b101:  taken = flag_n || flag_z;
            3'b110:  taken = flag_v;
            default: taken = 1'b1;
        endcase
    end

    always_comb begin
        resolved_pc = seq_pc;
        if (instr_reg[15:12] == OP_B && taken) begin
            resolved_pc = seq_pc + branch_off;
        end else if (instr_reg[15:12] == OP_BR && taken) begin
            resolved_pc = br_target;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        unique case (state_reg)
            FETCH: begin
                if (started_reg && imem_rdy) begin
                    instr_next = imem_data;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ack) begin
                    if (instr_reg[15:12] == HLT_OPCODE) begin
                        state_next = HALT;
                    end else begin
                        pc_next    = resolved_pc;
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_comb begin
        imem_req    = (state_reg == FETCH) && started_reg;
        instr_valid = (state_reg == ISSUE);
        hlt         = (state_reg == HALT);
        imem_addr   = pc_reg;
        pc          = pc_reg;
        pc_plus2    = seq_pc;
        instr       = instr_reg;
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed branch/wrap/halt scenarios plus a
// randomized instruction stream checked against a spec-level next-PC model.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic [2:0]  flags_in = 3'b000;
    logic [15:0] br_reg = 16'h0000;
    logic [15:0] pc_plus2;
    logic [15:0] pc;
    logic        hlt;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] exp_pc = 16'h0000;

    fetch_pc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdy   (imem_rdy),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ack  (instr_ack),
        .flags_in   (flags_in),
        .br_reg     (br_reg),
        .pc_plus2   (pc_plus2),
        .pc         (pc),
        .hlt        (hlt)
    );

    always #5 clk = ~clk;

    // Next PC straight from the architectural rules, using plain integer arithmetic.
    function automatic logic [15:0] ref_next_pc(input logic [15:0] pc_now, input logic [15:0] w,
                                                input logic [2:0] f, input logic [15:0] br);
        int p, op, cc, o;
        bit z, v, n, tk;
        p  = int'(pc_now);
        op = int'(w[15:12]);
        cc = int'(w[11:9]);
        o  = int'(w[8:0]);
        if (o > 255) o = o - 512;
        z = f[2]; v = f[1]; n = f[0];
        case (cc)
            0: tk = !z;
            1: tk = z;
            2: tk = !z && !n;
            3: tk = n;
            4: tk = z || (!z && !n);
            5: tk = n || z;
            6: tk = v;
            default: tk = 1'b1;
        endcase
        if (op == 15) return pc_now;
        if (op == 12 && tk) return 16'(p + 2 + 2 * o);
        if (op == 13 && tk) return br & 16'hFFFE;
        return 16'(p + 2);
    endfunction

    // One full fetch+issue transaction, checking the handshakes and the resulting PC.
    task automatic run_instr(input logic [15:0] word, input int fwait, input int adelay,
                             input logic [2:0] flags, input logic [15:0] br, output int waited);
        int n = 0;
        logic [15:0] prev_pc;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        total++;
        if (n >= 20) begin
            $display("FAIL req_timeout imem_req=%b required=1", imem_req);
            return;
        end else passed++;
        for (int i = 0; i <= fwait; i++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0)
                $display("FAIL fetch req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                         imem_req, imem_addr, instr_valid, exp_pc);
            else passed++;
            imem_rdy  = (i == fwait);
            imem_data = (i == fwait) ? word : 16'($urandom);
            @(negedge clk);
        end
        imem_rdy  = 1'b0;
        imem_data = 16'($urandom);
        prev_pc   = exp_pc;
        for (int i = 0; i <= adelay; i++) begin
            total++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word || pc !== prev_pc ||
                pc_plus2 !== 16'(prev_pc + 16'd2))
                $display("FAIL issue valid=%b req=%b instr=%h pc=%h pc_plus2=%h required 1 0 %h %h %h",
                         instr_valid, imem_req, instr, pc, pc_plus2, word, prev_pc, 16'(prev_pc + 16'd2));
            else passed++;
            if (i == adelay) begin
                instr_ack = 1'b1;
                flags_in  = flags;
                br_reg    = br;
            end
            @(negedge clk);
        end
        instr_ack = 1'b0;
        flags_in  = 3'($urandom);
        br_reg    = 16'($urandom);
        exp_pc    = ref_next_pc(prev_pc, word, flags, br);
        total++;
        if (pc !== exp_pc || instr_valid !== 1'b0 || hlt !== (word[15:12] == 4'hF) ||
            imem_req !== (word[15:12] != 4'hF))
            $display("FAIL after_ack instr=%h pc=%h valid=%b hlt=%b req=%b required pc=%h valid=0 hlt=%b req=%b",
                     word, pc, instr_valid, hlt, imem_req, exp_pc,
                     word[15:12] == 4'hF, word[15:12] != 4'hF);
        else passed++;
        $display("txn instr=%h pc %h -> %h flags=%b br=%h fwait=%0d adelay=%0d",
                 word, prev_pc, pc, flags, br, fwait, adelay);
    endtask

    task automatic goto_pc(input logic [15:0] target);
        int w;
        run_instr(16'hDE00, 0, 0, 3'b000, target, w);
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 || hlt !== 1'b0 || pc !== 16'h0000)
            $display("FAIL reset req=%b valid=%b instr=%h hlt=%b pc=%h required 0 0 0000 0 0000",
                     imem_req, instr_valid, instr, hlt, pc);
        else passed++;
        rst_n  = 1'b1;
        exp_pc = 16'h0000;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
            $display("FAIL first_req req=%b addr=%h required 1 0000", imem_req, imem_addr);
        else passed++;
        run_instr(16'h0123, 0, 0, 3'b000, 16'h0000, w);
        run_instr(16'h0456, 0, 0, 3'b000, 16'h0000, w);
        total++;
        if (w !== 0) $display("FAIL throughput extra_cycles=%0d required 0", w);
        else passed++;
        run_instr(16'h0789, 0, 0, 3'b000, 16'h0000, w);
        total++;
        if (w !== 0 || pc !== 16'h0006 || hlt !== 1'b0)
            $display("FAIL seq extra=%0d pc=%h hlt=%b required 0 0006 0", w, pc, hlt);
        else passed++;
    endtask

    task automatic test_wait_states();
        int w;
        run_instr(16'h2222, 3, 2, 3'b000, 16'h0000, w);
        run_instr(16'h3333, 1, 0, 3'b111, 16'hABCD, w);
    endtask

    task automatic test_branch();
        int w;
        goto_pc(16'h0010);
        run_instr(16'hC3FE, 0, 0, 3'b100, 16'h0000, w);
        total++;
        if (pc !== 16'h000E) $display("FAIL b_eq_taken pc=%h required 000E", pc); else passed++;
        goto_pc(16'h0010);
        run_instr(16'hC3FE, 0, 1, 3'b000, 16'h0000, w);
        total++;
        if (pc !== 16'h0012) $display("FAIL b_eq_not pc=%h required 0012", pc); else passed++;
        goto_pc(16'h0010);
        run_instr(16'hCE01, 0, 0, 3'b000, 16'h0000, w);
        total++;
        if (pc !== 16'h0014) $display("FAIL b_always pc=%h required 0014", pc); else passed++;
        goto_pc(16'h0020);
        run_instr(16'hDC00, 0, 0, 3'b010, 16'h1235, w);
        total++;
        if (pc !== 16'h1234) $display("FAIL br_ov_taken pc=%h required 1234", pc); else passed++;
        goto_pc(16'h0020);
        run_instr(16'hDC00, 0, 0, 3'b000, 16'h1235, w);
        total++;
        if (pc !== 16'h0022) $display("FAIL br_ov_not pc=%h required 0022", pc); else passed++;
        goto_pc(16'h0030);
        run_instr(16'hE000, 0, 2, 3'b000, 16'h0000, w);
    endtask

    task automatic test_wrap();
        int w;
        goto_pc(16'hFFFE);
        run_instr(16'h0001, 0, 0, 3'b000, 16'h0000, w);
        total++;
        if (pc !== 16'h0000) $display("FAIL wrap_seq pc=%h required 0000", pc); else passed++;
        goto_pc(16'hFFFC);
        run_instr(16'hCE02, 0, 0, 3'b000, 16'h0000, w);
        total++;
        if (pc !== 16'h0002) $display("FAIL wrap_branch pc=%h required 0002", pc); else passed++;
    endtask

    task automatic test_random();
        int w;
        logic [15:0] word;
        for (int k = 0; k < 40; k++) begin
            word = {4'($urandom_range(0, 14)), 12'($urandom)};
            run_instr(word, $urandom_range(0, 3), $urandom_range(0, 2), 3'($urandom), 16'($urandom), w);
        end
    endtask

    task automatic test_halt_and_reset();
        int w;
        goto_pc(16'h0040);
        run_instr(16'hF000, 0, 1, 3'b000, 16'h0000, w);
        for (int i = 0; i < 8; i++) begin
            imem_rdy  = 1'b1;
            instr_ack = 1'b1;
            imem_data = 16'($urandom);
            @(negedge clk);
            total++;
            if (hlt !== 1'b1 || pc !== 16'h0040 || imem_req !== 1'b0 || instr_valid !== 1'b0)
                $display("FAIL halt_hold hlt=%b pc=%h req=%b valid=%b required 1 0040 0 0",
                         hlt, pc, imem_req, instr_valid);
            else passed++;
        end
        imem_rdy  = 1'b0;
        instr_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (hlt !== 1'b0 || pc !== 16'h0000 || imem_req !== 1'b0)
            $display("FAIL halt_reset hlt=%b pc=%h req=%b required 0 0000 0", hlt, pc, imem_req);
        else passed++;
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 16'h0000;
        goto_pc(16'h0100);
        // Reset while the fetch of 0x0100 is outstanding, with a response on the bus.
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100)
            $display("FAIL midfetch_pre req=%b addr=%h required 1 0100", imem_req, imem_addr);
        else passed++;
        imem_rdy  = 1'b1;
        imem_data = 16'hC1FF;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (hlt !== 1'b0 || pc !== 16'h0000 || imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL midfetch_reset hlt=%b pc=%h req=%b valid=%b required 0 0000 0 0",
                     hlt, pc, imem_req, instr_valid);
        else passed++;
        @(negedge clk);
        imem_rdy = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 16'h0000;
        run_instr(16'h0ABC, 0, 0, 3'b000, 16'h0000, w);
        total++;
        if (pc !== 16'h0002) $display("FAIL resume pc=%h required 0002", pc); else passed++;
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_branch();
        test_wrap();
        test_random();
        test_halt_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Instruction-fetch and PC-control stage that sits directly upstream of the cpu decode/execute datapath. It owns the program counter and fetches 16-bit instructions from instruction memory over a req/rdy handshake. It presents each instruction to execute over a valid/ack handshake, then resolves the next PC for B, BR, PCS and HLT using the condition flags and register operand returned by execute.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HLT_OPCODE, 4'hF, opcode (instr[15:12]) that halts fetch.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  active-low reset; asynchronous assertion.
imem_addr  output  16  fetch address; equals pc while imem_req is high.
imem_req  output  1  fetch request; held high until imem_rdy.
imem_rdy  input  1  instruction memory returns imem_data this cycle.
imem_data  input  16  fetched instruction word.
instr  output  16  instruction presented to execute; stable while instr_valid.
instr_valid  output  1  instr is valid and awaiting acceptance.
instr_ack  input  1  execute has consumed instr; flags_in and br_reg are valid this cycle.
flags_in  input  3  {Z,V,N} from the flag register, sampled on instr_ack.
br_reg  input  16  register value for the BR target, sampled on instr_ack.
pc_plus2  output  16  pc+2 (mod 2^16); PCS writeback value.
pc  output  16  current PC.
hlt  output  1  high once the HLT instruction has been accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n is low: state=FETCH, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, hlt=0. imem_req first rises in the first clk edge after rst_n goes high.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On imem_rdy, latch imem_data into instr, drop imem_req and go to ISSUE. imem_rdy in the same cycle that imem_req rises is legal, giving 1-cycle fetch latency. Wait states are unbounded.
  - ISSUE: instr_valid=1 and instr is held. With no instr_ack, stay in ISSUE. On instr_ack, update pc per the next-PC rules, drop instr_valid and go to FETCH. If the opcode is HLT_OPCODE, go to HALT instead.
  - HALT: hlt=1, instr_valid=0, imem_req=0, and pc is frozen at the HLT instruction's address. Only reset exits HALT.
- imem_rdy is ignored outside FETCH. instr_ack is ignored outside ISSUE.
- Next-PC rules (all arithmetic mod 2^16, so 0xFFFE+2 = 0x0000):
  - Default: pc <= pc+2.
  - B (opcode 1100): ccc=instr[11:9], off=signext(instr[8:0])<<1. If taken, pc <= pc+2+off; else pc+2.
  - BR (opcode 1101): ccc=instr[11:9]. If taken, pc <= {br_reg[15:1],1'b0}; else pc+2.
  - PCS (opcode 1110): pc <= pc+2. The pc_plus2 output is valid throughout ISSUE.
  - HLT: pc unchanged.
- Condition codes, evaluated from flags_in at instr_ack:
  - 000 NE: Z==0
  - 001 EQ: Z==1
  - 010 GT: Z==0 && N==0
  - 011 LT: N==1
  - 100 GE: Z==1 || (Z==0 && N==0)
  - 101 LE: N==1 || Z==1
  - 110 OV: V==1
  - 111 always taken
- Reset mid-operation: asynchronous return to reset values from any state, including mid-FETCH with imem_req high. Any pending memory response is discarded.
- No output is combinationally dependent on instr_ack or imem_rdy. Exception: none; all outputs are registered or derived from registered pc/state.

Test Plan:
- Reset with RESET_PC=0, rdy tied 1, ack tied 1, program ADD,ADD,ADD -> imem_addr sequence 0x0000,0x0002,0x0004, one instruction per 2 cycles, hlt=0.
- Fetch with 3 wait cycles -> imem_req high 4 cycles at a constant address, instr_valid only after rdy. Ack delayed 2 cycles -> instr stable, pc unchanged until ack.
- B at pc=0x0010:
  - instr=0xC3FE (ccc=001, off=-4), Z=1 -> pc=0x000E.
  - Same instr with Z=0 -> pc=0x0012.
  - ccc=111, off=+2 -> pc=0x0014.
- BR at pc=0x0020, ccc=110: V=1, br_reg=0x1235 -> pc=0x1234. V=0 -> pc=0x0022. PCS at pc=0x0030 -> pc_plus2=0x0032 during ISSUE.
- Wrap: pc=0xFFFE non-branch -> pc=0x0000. B at pc=0xFFFC with off=+4 -> pc=0x0002.
- HLT at pc=0x0040 -> after ack hlt=1, pc=0x0040, imem_req=0 indefinitely. Pulse rst_n low mid-FETCH -> hlt=0, pc=0x0000, imem_req=0 immediately, then fetch resumes from 0x0000.
